io_mmio_ctrl: RTL and testbench
===============================

Name: io_mmio_ctrl

Overview:
- Parametrised memory-mapped I/O controller. It sits between the CPU data path (ALU address, store data, memory read data) and the board peripherals.
- Provides NUM_IN latched switch-input channels, a test-switch port, and a FIFO-queued 7-seg display with programmable per-entry hold time.
- Also provides an LED register, a blink timer, and a status register with overflow and queue-occupancy reporting.
- Next generation of the single-queue IO block: generalised widths, depth and channels, plus flush, status and hold-time control.

Parameters:
- DATA_W, 32, CPU data/address width
- IN_W, 8, width of each switch-input channel
- NUM_IN, 2, number of latched input channels (1..4)
- TEST_W, 3, test-switch width
- SEG_W, 24, 7-seg payload width
- LED_W, 24, LED register width
- QDEPTH, 32, display FIFO depth (power of 2, >=2)
- HOLD_RST, 100000000, reset display hold time in cycles
- BASE, 32'hFFFF_FC00, base address of the I/O window

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- io_read  in  1  CPU I/O read strobe
- io_write  in  1  CPU I/O write strobe
- alu_result  in  DATA_W  access address
- read_data_2  in  DATA_W  store data
- mem_read_data  in  DATA_W  data-memory read data
- io_input  in  IN_W  switch bank
- enter  in  NUM_IN  per-channel capture buttons (asynchronous)
- test_input  in  TEST_W  test switches
- memorio_result  out  DATA_W  load result
- seg_out  out  SEG_W  display payload
- led_out  out  LED_W  LED drive
- blink_out  out  1  blink indicator

Behaviour:
- Reset: all outputs 0; queue empty; hold_reg=HOLD_RST; all latches, counters and the overflow flag cleared. Reset is asynchronous and active-low (rst_n).
- Address map, offsets from BASE:
  - 0x00+4i: IN[i] (read)
  - 0x10: TEST (read)
  - 0x14: STATUS (read; write clears overflow)
  - 0x20: SEG push (write)
  - 0x24: LED (write)
  - 0x28: BLINK (write)
  - 0x2C: HOLD (read/write)
  - 0x30: FLUSH (write)
- Writes take effect at the rising edge where io_write=1 and the address matches exactly.
- Read path is combinational:
  - io_read=1 with a matching read address returns the zero-extended register.
  - Any other case returns mem_read_data.
- STATUS read value = {overflow at bit 31, full at bit 17, empty at bit 16, count at bits [15:0]}.
- Input capture:
  - Each enter[i] passes through a 2-flop synchronizer, then a rising-edge detector.
  - On the detected edge, IN[i] <= io_input. Capture latency is 3 cycles after the button rises.
- Display FIFO: circular buffer with read pointer, write pointer and count (0..QDEPTH). Pointers wrap QDEPTH-1 -> 0.
- Push (SEG write):
  - If not full, store read_data_2[SEG_W-1:0].
  - If full, drop the data and set overflow (sticky) — unless a pop occurs in the same cycle, in which case the push is accepted.
- Hold timer:
  - Timer loads max(hold_reg,1)-1 when the queue goes empty -> non-empty, and on every pop that leaves the queue non-empty.
  - While count>0 the timer decrements each cycle; when it is 0, pop.
  - Each entry is displayed for exactly max(hold_reg,1) cycles.
- seg_out is registered: it equals the head entry when count>0, otherwise 0.
  - A push into an empty queue appears on seg_out the next cycle.
- HOLD write:
  - Updates hold_reg.
  - The running entry keeps its current timer; the new value applies from the next load.
- FLUSH write:
  - Next cycle: count=0, pointers equal, seg_out=0.
  - Same-cycle FLUSH and SEG push: flush first, then push, so the queue holds exactly the new entry.
- LED write: led_out <= read_data_2[LED_W-1:0].
- Blink:
  - A BLINK write loads blink_cnt <= read_data_2; a write of 0 cancels.
  - blink_cnt decrements each cycle while non-zero.
  - blink_out = (blink_cnt!=0), registered. A write takes priority over the decrement.
- Reset asserted mid-operation: everything returns to reset values immediately. Queue contents need not be cleared (they are invisible because count=0).

Decomposition:
- Shared package/defines file holds the address offsets, STATUS bit positions and HOLD_RST default.
- One sub-module: io_disp_fifo (circular buffer + hold timer + flush). Parameters: QDEPTH, SEG_W. Interface: push/data/flush/hold in; head/count/full/empty/overflow_evt out.
- Synchronizer and edge detector are inlined in io_mmio_ctrl.

Test Plan:
- QDEPTH=4, HOLD=3 (written at 0x2C). Push 0x11, 0x22 back-to-back -> seg_out shows 0x11 for 3 cycles, then 0x22 for 3 cycles, then 0. STATUS count reads 2, then 1, then 0.
- QDEPTH=4, HOLD=100. Five pushes -> fifth dropped; STATUS = 0x8002_0004. Write STATUS -> bit 31 clears; count is unchanged.
- Three entries queued, HOLD=100; write FLUSH and push 0x55 in the same cycle -> next cycle count=1, seg_out=0x55.
- io_input=0xA5, pulse enter[1] -> read at BASE+0x04 returns 0x0000_00A5 from cycle 3 onward; IN[0] stays 0. Read of an unmapped address returns mem_read_data.
- Write BLINK=4 -> blink_out high for exactly 4 cycles. Rewrite 4 at cycle 2 -> high 6 cycles total. Write 0 -> low the next cycle.
- Assert rst_n=0 mid-display, with led_out=0xFFFF -> all outputs 0 immediately. After release, HOLD reads HOLD_RST and STATUS reads 0x0001_0000.

Source files
------------

// File: rtl/io_mmio_ctrl_pkg.sv
// Shared constants for the MMIO controller: window offsets, STATUS layout
// and the default display hold time.
package io_mmio_ctrl_pkg;

    // Byte offsets from BASE
    localparam int OFF_IN     = 'h00;  // IN[i] at OFF_IN + 4*i
    localparam int OFF_TEST   = 'h10;
    localparam int OFF_STATUS = 'h14;
    localparam int OFF_SEG    = 'h20;
    localparam int OFF_LED    = 'h24;
    localparam int OFF_BLINK  = 'h28;
    localparam int OFF_HOLD   = 'h2C;
    localparam int OFF_FLUSH  = 'h30;

    // STATUS word layout
    localparam int ST_OVF_BIT   = 31;
    localparam int ST_FULL_BIT  = 17;
    localparam int ST_EMPTY_BIT = 16;
    localparam int ST_CNT_W     = 16;

    // One second at 100 MHz
    localparam int unsigned HOLD_RST_DEF = 100000000;

endpackage

// File: rtl/io_mmio_ctrl_disp_fifo.sv
// Display queue: circular buffer with per-entry hold timer and flush.
// head is registered; it shows the oldest entry while the queue is non-empty.
module io_disp_fifo #(
    parameter  int QDEPTH = 32,
    parameter  int SEG_W  = 24,
    parameter  int HOLD_W = 32,
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [SEG_W-1:0]  push_data,
    input  logic              flush,
    input  logic [HOLD_W-1:0] hold,
    output logic [SEG_W-1:0]  head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow_evt
);

    logic [SEG_W-1:0]  mem [QDEPTH];
    logic [PTR_W-1:0]  rptr, wptr, rptr_n, wptr_n;
    logic [CNT_W-1:0]  cnt_eff, count_n;
    logic [HOLD_W-1:0] timer, timer_n, hold_m1;
    logic [SEG_W-1:0]  head_n;
    logic              pop, accept, full_eff;

    assign full  = (count == CNT_W'(QDEPTH));
    assign empty = (count == '0);

    // Next-state: flush is applied before the push so a same-cycle push survives
    always_comb begin
        cnt_eff      = flush ? '0 : count;
        full_eff     = (cnt_eff == CNT_W'(QDEPTH));
        pop          = !flush && (count != '0) && (timer == '0);
        accept       = push && (!full_eff || pop);
        overflow_evt = push && full_eff && !pop;
        rptr_n       = flush ? wptr : (pop ? rptr + 1'b1 : rptr);
        wptr_n       = accept ? wptr + 1'b1 : wptr;
        count_n      = cnt_eff + CNT_W'(accept) - CNT_W'(pop);
        // A hold of 0 behaves as 1 so every entry is shown at least one cycle
        hold_m1      = (hold == '0) ? '0 : hold - 1'b1;
        timer_n      = timer;
        if (accept && cnt_eff == '0)
            timer_n = hold_m1;
        else if (pop && count_n != '0)
            timer_n = hold_m1;
        else if (count != '0 && timer != '0)
            timer_n = timer - 1'b1;
        // New head may be the word being written this cycle
        head_n = '0;
        if (count_n != '0)
            head_n = (accept && rptr_n == wptr) ? push_data : mem[rptr_n];
    end

    // Pointer, occupancy, timer and head registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            timer <= '0;
            head  <= '0;
        end else begin
            rptr  <= rptr_n;
            wptr  <= wptr_n;
            count <= count_n;
            timer <= timer_n;
            head  <= head_n;
        end
    end

    // Storage; contents are don't-care while count is 0, so no reset
    always_ff @(posedge clk) begin
        if (accept)
            mem[wptr] <= push_data;
    end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller: latched switch inputs, test switches,
// queued 7-seg display, LED register, blink timer and STATUS.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              IN_W     = 8,
    parameter int              NUM_IN   = 2,
    parameter int              TEST_W   = 3,
    parameter int              SEG_W    = 24,
    parameter int              LED_W    = 24,
    parameter int              QDEPTH   = 32,
    parameter int unsigned     HOLD_RST = HOLD_RST_DEF,
    parameter logic [DATA_W-1:0] BASE   = 32'hFFFF_FC00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_read,
    input  logic              io_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [IN_W-1:0]   io_input,
    input  logic [NUM_IN-1:0] enter,
    input  logic [TEST_W-1:0] test_input,
    output logic [DATA_W-1:0] memorio_result,
    output logic [SEG_W-1:0]  seg_out,
    output logic [LED_W-1:0]  led_out,
    output logic              blink_out
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [NUM_IN-1:0][IN_W-1:0] in_reg;
    logic [DATA_W-1:0] hold_reg, blink_cnt, blink_cnt_n, status_word;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, ovf_evt, overflow;
    logic hit_test, hit_status, hit_seg, hit_led, hit_blink, hit_hold, hit_flush;

    assign hit_test   = (alu_result == BASE + DATA_W'(OFF_TEST));
    assign hit_status = (alu_result == BASE + DATA_W'(OFF_STATUS));
    assign hit_seg    = (alu_result == BASE + DATA_W'(OFF_SEG));
    assign hit_led    = (alu_result == BASE + DATA_W'(OFF_LED));
    assign hit_blink  = (alu_result == BASE + DATA_W'(OFF_BLINK));
    assign hit_hold   = (alu_result == BASE + DATA_W'(OFF_HOLD));
    assign hit_flush  = (alu_result == BASE + DATA_W'(OFF_FLUSH));

    // Per-channel button sync (2 flops) + rising-edge capture of io_input
    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        logic [2:0]      enter_pipe;  // [1:0] synchronizer, [2] previous level
        logic [IN_W-1:0] cap_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                enter_pipe <= '0;
                cap_q      <= '0;
            end else begin
                enter_pipe <= {enter_pipe[1:0], enter[g]};
                if (enter_pipe[1] && !enter_pipe[2])
                    cap_q <= io_input;
            end
        end
        assign in_reg[g] = cap_q;
    end

    // STATUS word assembly
    always_comb begin
        status_word                 = '0;
        status_word[ST_CNT_W-1:0]   = ST_CNT_W'(fifo_count);
        status_word[ST_EMPTY_BIT]   = fifo_empty;
        status_word[ST_FULL_BIT]    = fifo_full;
        status_word[ST_OVF_BIT]     = overflow;
    end

    // Combinational read mux; unmapped or non-I/O reads pass memory data
    always_comb begin
        memorio_result = mem_read_data;
        if (io_read) begin
            for (int i = 0; i < NUM_IN; i++)
                if (alu_result == BASE + DATA_W'(OFF_IN + 4 * i))
                    memorio_result = DATA_W'(in_reg[i]);
            if (hit_test)   memorio_result = DATA_W'(test_input);
            if (hit_status) memorio_result = status_word;
            if (hit_hold)   memorio_result = hold_reg;
        end
    end

    // Blink counter: a write overrides the running decrement
    always_comb begin
        blink_cnt_n = blink_cnt;
        if (io_write && hit_blink)
            blink_cnt_n = read_data_2;
        else if (blink_cnt != '0)
            blink_cnt_n = blink_cnt - 1'b1;
    end

    // Control registers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= DATA_W'(HOLD_RST);
            led_out   <= '0;
            blink_cnt <= '0;
            blink_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (io_write && hit_hold) hold_reg <= read_data_2;
            if (io_write && hit_led)  led_out  <= read_data_2[LED_W-1:0];
            blink_cnt <= blink_cnt_n;
            blink_out <= (blink_cnt_n != '0);
            if (io_write && hit_status) overflow <= 1'b0;
            else if (ovf_evt)           overflow <= 1'b1;
        end
    end

    io_disp_fifo #(
        .QDEPTH (QDEPTH),
        .SEG_W  (SEG_W),
        .HOLD_W (DATA_W)
    ) u_disp_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (io_write && hit_seg),
        .push_data    (read_data_2[SEG_W-1:0]),
        .flush        (io_write && hit_flush),
        .hold         (hold_reg),
        .head         (seg_out),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow_evt (ovf_evt)
    );

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Bench for io_mmio_ctrl: display queue, overflow, flush, input capture,
// blink timing and asynchronous reset.
module tb_io_mmio_ctrl;

    localparam logic [31:0] BASE  = 32'hFFFF_FC00;
    localparam int          HRST  = 50;
    localparam logic [31:0] A_IN0 = 'h00, A_IN1 = 'h04, A_TEST = 'h10, A_ST = 'h14,
                            A_SEG = 'h20, A_LED = 'h24, A_BLK = 'h28, A_HOLD = 'h2C,
                            A_FLUSH = 'h30;

    logic        clk = 0, rst_n = 0;
    logic        io_read = 0, io_write = 0;
    logic [31:0] alu_result = '0, read_data_2 = '0, mem_read_data = 32'h1234_5678;
    logic [7:0]  io_input = '0;
    logic [1:0]  enter = '0;
    logic [2:0]  test_input = '0;
    logic [31:0] memorio_result;
    logic [23:0] seg_out, led_out;
    logic        blink_out;

    int errs = 0, checks = 0;
    logic [31:0] seg_q[$], st_q[$];

    io_mmio_ctrl #(.QDEPTH(4), .HOLD_RST(HRST)) dut (
        .clk(clk), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
        .alu_result(alu_result), .read_data_2(read_data_2),
        .mem_read_data(mem_read_data), .io_input(io_input), .enter(enter),
        .test_input(test_input), .memorio_result(memorio_result),
        .seg_out(seg_out), .led_out(led_out), .blink_out(blink_out));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int cnt, input bit ovf);
        return {ovf, 13'b0, cnt == 4, cnt == 0, 16'(cnt)};
    endfunction

    // Queue expected seg_out and STATUS for the next observation
    task automatic expect_q(input logic [31:0] seg, input int cnt, input bit ovf);
        seg_q.push_back(seg);
        st_q.push_back(st(cnt, ovf));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        io_write = 1; alu_result = BASE + off; read_data_2 = d;
        @(posedge clk); #1;
        io_write = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        io_read = 1; alu_result = BASE + off; #1;
        chk(tag, memorio_result, exp);
        io_read = 0;
    endtask

    // Pop the oldest expectation and compare seg_out and STATUS
    task automatic obs(input string tag);
        logic [31:0] es, et;
        if (seg_q.size() == 0 || st_q.size() == 0) begin
            checks++; errs++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        es = seg_q.pop_front();
        et = st_q.pop_front();
        chk({tag, ".seg"}, 32'(seg_out), es);
        rd_chk({tag, ".st"}, A_ST, et);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.seg", 32'(seg_out), 0);
        chk("rst.led", 32'(led_out), 0);
        chk("rst.blink", 32'(blink_out), 0);
        chk("rst.mem", memorio_result, 32'h1234_5678);
        @(negedge clk); rst_n = 1;
        rd_chk("rst.hold", A_HOLD, HRST);
        rd_chk("rst.st", A_ST, 32'h0001_0000);

        // Two entries, hold 3 cycles each
        wr(A_HOLD, 3);
        expect_q(24'h11, 1, 0); wr(A_SEG, 32'h11); obs("q1");
        expect_q(24'h11, 2, 0); wr(A_SEG, 32'h22); obs("q2");
        expect_q(24'h11, 2, 0); expect_q(24'h22, 1, 0); expect_q(24'h22, 1, 0);
        expect_q(24'h22, 1, 0); expect_q(24'h00, 0, 0);
        repeat (5) begin tick(); obs("q_run"); end

        // Overflow on fifth push, STATUS write clears only the flag
        wr(A_HOLD, 100);
        for (int i = 1; i <= 5; i++) begin
            expect_q(24'h1, (i > 4) ? 4 : i, i > 4);
            wr(A_SEG, i);
            obs("ovf");
        end
        expect_q(24'h1, 4, 0); wr(A_ST, 0); obs("ovf_clr");

        // Flush, refill three, flush then push
        expect_q(0, 0, 0); wr(A_FLUSH, 0); obs("fl0");
        for (int i = 1; i <= 3; i++) begin
            expect_q(24'hA0, i, 0); wr(A_SEG, 32'hA0 + i - 1); obs("fill");
        end
        expect_q(0, 0, 0);     wr(A_FLUSH, 0);     obs("fl1");
        expect_q(24'h55, 1, 0); wr(A_SEG, 32'h55); obs("fl_push");
        expect_q(0, 0, 0);     wr(A_FLUSH, 0);     obs("fl2");

        // Hold of 0 shows an entry for one cycle
        wr(A_HOLD, 0);
        rd_chk("hold0.rd", A_HOLD, 0);
        expect_q(24'h99, 1, 0); wr(A_SEG, 32'h99); obs("h0a");
        expect_q(0, 0, 0); tick(); obs("h0b");

        // Push into a full queue on the pop cycle is accepted
        wr(A_HOLD, 5);
        for (int i = 1; i <= 4; i++) begin
            expect_q(24'hB1, i, 0); wr(A_SEG, 32'hB0 + i); obs("fullpop");
        end
        expect_q(24'hB1, 4, 0); tick(); obs("fp_idle");
        expect_q(24'hB2, 4, 0); wr(A_SEG, 32'hB5); obs("fp_push");
        expect_q(0, 0, 0); wr(A_FLUSH, 0); obs("fl3");

        // Input capture on channel 1
        @(negedge clk); io_input = 8'hA5; enter = 2'b10; test_input = 3'b101;
        tick(); tick();
        rd_chk("in1.early", A_IN1, 0);
        tick();
        rd_chk("in1.cap", A_IN1, 32'h0000_00A5);
        rd_chk("in0.idle", A_IN0, 0);
        io_input = 8'h3C;
        tick(); tick();
        rd_chk("in1.hold", A_IN1, 32'h0000_00A5);
        rd_chk("test", A_TEST, 5);
        rd_chk("unmapped", 'h08, 32'h1234_5678);
        io_read = 0; alu_result = BASE + A_IN1; #1;
        chk("noread", memorio_result, 32'h1234_5678);
        enter = 0;

        // Blink: 4 cycles, rewrite extends to 6, zero cancels
        wr(A_BLK, 4); chk("b4.0", 32'(blink_out), 1);
        for (int i = 1; i < 4; i++) begin tick(); chk("b4.on", 32'(blink_out), 1); end
        tick(); chk("b4.off", 32'(blink_out), 0);
        wr(A_BLK, 4); chk("b6.0", 32'(blink_out), 1);
        tick();       chk("b6.1", 32'(blink_out), 1);
        wr(A_BLK, 4); chk("b6.2", 32'(blink_out), 1);
        for (int i = 3; i < 6; i++) begin tick(); chk("b6.on", 32'(blink_out), 1); end
        tick(); chk("b6.off", 32'(blink_out), 0);
        wr(A_BLK, 4); chk("bc.on", 32'(blink_out), 1);
        wr(A_BLK, 0); chk("bc.off", 32'(blink_out), 0);

        // Asynchronous reset mid-display
        wr(A_LED, 32'hFFFF); chk("led", 32'(led_out), 32'hFFFF);
        wr(A_BLK, 100);
        wr(A_HOLD, 3);
        wr(A_SEG, 32'h77); chk("pre_rst.seg", 32'(seg_out), 32'h77);
        mem_read_data = 0;
        #2 rst_n = 0; #1;
        chk("arst.seg", 32'(seg_out), 0);
        chk("arst.led", 32'(led_out), 0);
        chk("arst.blink", 32'(blink_out), 0);
        chk("arst.mem", memorio_result, 0);
        @(negedge clk); rst_n = 1;
        rd_chk("arst.hold", A_HOLD, HRST);
        rd_chk("arst.st", A_ST, 32'h0001_0000);
        tick(); chk("arst.seg2", 32'(seg_out), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: timeout, errors=%0d", errs);
        $fatal(1);
    end

endmodule
